// File: rtl/tristate_bus_arb.sv
// Purpose : round-robin owner selection and en/en_b generation for a shared tristate bus.
// Latency : req->gnt 1 clk, req->en/bus_vld 2 clk; en falls 1 clk after req[owner]=0 is sampled.
// Backpres: a requester waits, holding req, until granted; ownership always passes through a dead TURN cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset_b  asynchronous active-low reset; floats the bus immediately
//   req      per-source bus request, held until the matching gnt falls
//   gnt      one-hot grant; the granted source keeps its data stable while high
//   en/en_b  per-source tristate enables, both registered (en_b is the complement of en)
//   owner    index of the current or most recent grantee
//   bus_vld  high in every cycle the bus is driven (one beat)
// Optional feature: define TRIBUS_BURST_LIMIT_EN to force a turnaround after MAX_BEATS
// DRIVE beats, so that one source cannot hold the bus indefinitely.

module tristate_bus_arb #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 8
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         en,
  output logic [NREQ-1:0]         en_b,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    bus_vld
);

  localparam int IDX_W = $clog2(NREQ);

  // Catch unusable configurations when the design is elaborated.
  if (NREQ < 2) begin : g_bad_nreq
    $error("tristate_bus_arb: NREQ must be >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("tristate_bus_arb: WIDTH must be >= 1");
  end
  if (MAX_BEATS < 1) begin : g_bad_beats
    $error("tristate_bus_arb: MAX_BEATS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, TURN} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   en_q, en_d;
  logic [NREQ-1:0]   en_b_q, en_b_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              bus_vld_q, bus_vld_d;

  logic [IDX_W-1:0]  win;
  logic              win_vld;
  logic              burst_done;

`ifdef TRIBUS_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  // The counter holds the beats already completed, so the edge that completes
  // beat MAX_BEATS sees MAX_BEATS-1 here.
  assign burst_done = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
`else
  assign burst_done = 1'b0;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Round-robin search: the first requester found starting at rr_ptr wins.
  always_comb begin
    int idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    en_d      = en_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    bus_vld_d = bus_vld_q;
`ifdef TRIBUS_BURST_LIMIT_EN
    beat_cnt_d = beat_cnt_q;
`endif
    case (state_q)
      // TURN is the dead cycle. It arbitrates exactly as IDLE does, so a req
      // that rises during TURN competes in that same arbitration.
      IDLE, TURN: begin
        state_d   = IDLE;
        gnt_d     = '0;
        en_d      = '0;
        bus_vld_d = 1'b0;
        if (win_vld) begin
          state_d  = SETUP;
          gnt_d    = onehot(win);
          owner_d  = win;
          rr_ptr_d = (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      SETUP: begin
        if (req[owner_q]) begin
          state_d   = DRIVE;
          en_d      = gnt_q;
          bus_vld_d = 1'b1;
`ifdef TRIBUS_BURST_LIMIT_EN
          beat_cnt_d = '0;
`endif
        end else begin
          // The source withdrew before driving. Nothing was enabled, so the
          // next owner needs no turnaround.
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      DRIVE: begin
`ifdef TRIBUS_BURST_LIMIT_EN
        beat_cnt_d = beat_cnt_q + 1'b1;
`endif
        if (!req[owner_q] || burst_done) begin
          state_d   = TURN;
          gnt_d     = '0;
          en_d      = '0;
          bus_vld_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        en_d      = '0;
        bus_vld_d = 1'b0;
      end
    endcase
    en_b_d = ~en_d;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      en_q      <= '0;
      en_b_q    <= '1;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      bus_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      en_q      <= en_d;
      en_b_q    <= en_b_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      bus_vld_q <= bus_vld_d;
    end
  end

`ifdef TRIBUS_BURST_LIMIT_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`endif

  assign gnt     = gnt_q;
  assign en      = en_q;
  assign en_b    = en_b_q;
  assign owner   = owner_q;
  assign bus_vld = bus_vld_q;

endmodule

// File: tb/tb_tristate_bus_arb.sv
// Purpose : bench for tristate_bus_arb -- directed scenarios plus random request streams
// Latency : n/a (bench)
// Backpres: random sources hold req until their grant falls; they may drop req in SETUP or DRIVE

module tb_tristate_bus_arb;

  localparam int NREQ      = 4;
  localparam int MAX_BEATS = 8;

  logic            clk = 1'b0;
  logic            reset_b = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt, en, en_b;
  logic [1:0]      owner;
  logic            bus_vld;

  always #5 clk = ~clk;

  tristate_bus_arb #(.NREQ(NREQ), .WIDTH(8), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .reset_b(reset_b), .req(req), .gnt(gnt), .en(en),
    .en_b(en_b), .owner(owner), .bus_vld(bus_vld)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  //   m_gnt   : granted source, or -1 when nobody holds a grant
  //   m_drv   : the grantee is currently driving
  //   m_beats : beats completed in the current tenure
  int m_gnt, m_owner, m_rr, m_beats;
  bit m_drv;
  logic [NREQ-1:0] prev_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gnt = -1; m_drv = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    prev_en = '0;
  endtask

  // One clock edge of the arbitration rules, applied to the sampled request vector r.
  task automatic model_step(input logic [NREQ-1:0] r);
    bit found;
    if (m_gnt < 0) begin
      // Idle or turnaround: pick the first requester at or after m_rr.
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_rr + k) % NREQ;
        if (!found && r[i]) begin
          found = 1; m_gnt = i; m_owner = i; m_rr = (i + 1) % NREQ;
        end
      end
    end else if (!m_drv) begin
      if (r[m_gnt]) begin m_drv = 1; m_beats = 0; end
      else m_gnt = -1;
    end else begin
      m_beats++;
`ifdef TRIBUS_BURST_LIMIT_EN
      if (!r[m_gnt] || m_beats == MAX_BEATS) begin m_drv = 0; m_gnt = -1; end
`else
      if (!r[m_gnt]) begin m_drv = 0; m_gnt = -1; end
`endif
    end
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] eg, ee, eb, nen;
    eg  = (m_gnt >= 0) ? NREQ'(1 << m_gnt) : '0;
    ee  = m_drv ? eg : '0;
    eb  = ~ee;
    nen = ~en;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("en", 32'(en), 32'(ee));
    chk("en_b", 32'(en_b), 32'(eb));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("bus_vld", 32'(bus_vld), 32'(m_drv));
    chk("en_onehot", 32'($countones(en) <= 1), 32'(1));
    chk("en_eq_not_en_b", 32'(en_b), 32'(nen));
    // Ownership may never pass from one enable straight to another.
    if (en != '0 && prev_en != '0) chk("no_direct_handover", 32'(en), 32'(prev_en));
    prev_en = en;
  endtask

  // Apply r from a falling edge, step the model at the rising edge, check at the next falling edge.
  task automatic cycle(input logic [NREQ-1:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    req = '0;
    reset_b = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    reset_b = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] r, prev_g;
    int nb, n_own, zrun, run;
    int owners[8];
    int runs[8];

    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_en_b", 32'(en_b), 32'(4'b1111));
    reset_b = 1'b1;

    // Single source: three beats, then a turnaround back to idle.
    cycle(4'b0100);
    chk("t2_gnt_p1", 32'(gnt), 32'(4'b0100));
    chk("t2_en_p1", 32'(en), 32'(0));
    cycle(4'b0100);
    chk("t2_en_p2", 32'(en), 32'(4'b0100));
    nb = int'(bus_vld);
    cycle(4'b0100); nb += int'(bus_vld);
    cycle(4'b0100); nb += int'(bus_vld);
    cycle(4'b0000); nb += int'(bus_vld);
    chk("t2_en_off", 32'(en), 32'(0));
    chk("t2_beats", 32'(nb), 32'(3));
    cycle(4'b0000);
    chk("t2_idle_gnt", 32'(gnt), 32'(0));

    // Abort in SETUP: the request is withdrawn the cycle gnt rises.
    cycle(4'b0010);
    chk("t5_gnt", 32'(gnt), 32'(4'b0010));
    cycle(4'b0000);
    chk("t5_no_en", 32'(en), 32'(0));
    chk("t5_gnt_clr", 32'(gnt), 32'(0));
    cycle(4'b0000);
    chk("t5_still_idle", 32'(en), 32'(0));

    // Asynchronous reset in the middle of a DRIVE cycle.
    cycle(4'b0001);
    cycle(4'b0001);
    chk("t1_driving", 32'(en), 32'(4'b0001));
    #2 reset_b = 1'b0;
    #1;
    chk("t1_en", 32'(en), 32'(0));
    chk("t1_en_b", 32'(en_b), 32'(4'b1111));
    chk("t1_gnt", 32'(gnt), 32'(0));
    chk("t1_bus_vld", 32'(bus_vld), 32'(0));
    req = '0;
    model_reset();
    @(negedge clk);
    reset_b = 1'b1;

    // Round robin with every source requesting; each owner drops after two beats.
    n_own = 0; zrun = 0;
    for (int c = 0; c < 80 && n_own < 5; c++) begin
      r = '1;
      if (m_drv && m_beats >= 1) r[m_gnt] = 1'b0;
      prev_g = gnt;
      cycle(r);
      if (gnt == '0) zrun++;
      if (gnt != '0 && prev_g == '0) begin
        owners[n_own] = int'(owner);
        // Consecutive tenures are separated by exactly one grant-free turnaround cycle.
        if (n_own > 0) chk("t3_turn_gap", 32'(zrun), 32'(1));
        n_own++;
        zrun = 0;
      end
    end
    chk("t3_grants", 32'(n_own), 32'(5));
    for (int i = 0; i < 5; i++) chk("t3_owner_seq", 32'(owners[i]), 32'(i % NREQ));
    for (int c = 0; c < 4; c++) cycle('0);

    // Two sources holding req: burst limit behaviour.
    do_reset();
    n_own = 0; run = 0;
    for (int c = 0; c < 40; c++) begin
      prev_g = gnt;
      cycle(4'b0011);
      if (bus_vld) run++;
      if (gnt != '0 && prev_g == '0 && n_own < 8) begin
        owners[n_own] = int'(owner);
        n_own++;
      end
      if (!bus_vld && run != 0) begin
        if (n_own > 0 && n_own <= 8) runs[n_own-1] = run;
        run = 0;
      end
    end
`ifdef TRIBUS_BURST_LIMIT_EN
    chk("t6_owner0", 32'(owners[0]), 32'(0));
    chk("t6_owner1", 32'(owners[1]), 32'(1));
    chk("t6_owner2", 32'(owners[2]), 32'(0));
    chk("t6_beats0", 32'(runs[0]), 32'(MAX_BEATS));
    chk("t6_beats1", 32'(runs[1]), 32'(MAX_BEATS));
`else
    chk("t6_single_grant", 32'(n_own), 32'(1));
    chk("t6_hold_en", 32'(en), 32'(4'b0001));
    chk("t6_hold_run", 32'(run), 32'(39));
`endif
    for (int c = 0; c < 4; c++) cycle('0);

    // Random, protocol-respecting request streams.
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt == i) begin
          if (m_drv) r[i] = ($urandom_range(0, 3) != 0);
          else       r[i] = ($urandom_range(0, 9) != 0);
        end else if (!r[i]) begin
          r[i] = ($urandom_range(0, 4) == 0);
        end
      end
      cycle(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
